// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: merges WB-stage writes and queued long-latency results into one register-file write port
//   Optional feature macro: SCOREBOARD_EN (busy bitmap + hazard; hazard tied 0 when undefined)
//   Ports: clk/rst (sync, active-high); wbEn/wbDest/wbVal WB request (top priority, no backpressure);
//          luValid/luDest/luVal/luReady long-latency result push; issueEn/issueDest mark outstanding dests;
//          src1/src2/hazard decode-stage hazard check; rfWriteEn/rfDest/rfWriteVal registered RF write;
//          qCount queue occupancy.
module reg_write_arbiter #(
    parameter int QDEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wbEn,
    input  logic [4:0]              wbDest,
    input  logic [31:0]             wbVal,
    input  logic                    luValid,
    input  logic [4:0]              luDest,
    input  logic [31:0]             luVal,
    output logic                    luReady,
    input  logic                    issueEn,
    input  logic [4:0]              issueDest,
    input  logic [4:0]              src1,
    input  logic [4:0]              src2,
    output logic                    hazard,
    output logic                    rfWriteEn,
    output logic [4:0]              rfDest,
    output logic [31:0]             rfWriteVal,
    output logic [$clog2(QDEPTH):0] qCount
);
    localparam int AW = $clog2(QDEPTH);
    localparam logic [AW:0] DEPTH = (AW + 1)'(QDEPTH);

    logic [4:0]    dest_q [QDEPTH];
    logic [31:0]   val_q  [QDEPTH];
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [AW:0]   count_q, count_d;
    logic          rf_we_q, rf_we_d;
    logic [4:0]    rf_dest_q, rf_dest_d;
    logic [31:0]   rf_val_q, rf_val_d;
    logic          wb_win, push, pop;

    assign luReady    = !rst && (count_q < DEPTH);
    assign wb_win     = wbEn && (wbDest != 5'd0);
    // Writes to r0 are accepted from the producer but never stored.
    assign push       = luValid && luReady && (luDest != 5'd0);
    // Pop decision uses the registered count, so a push into an empty queue cannot pop the same cycle.
    assign pop        = !wb_win && (count_q != '0);
    assign qCount     = count_q;
    assign rfWriteEn  = rf_we_q;
    assign rfDest     = rf_dest_q;
    assign rfWriteVal = rf_val_q;

    always_comb begin
        head_d    = pop ? head_q + 1'b1 : head_q;
        tail_d    = push ? tail_q + 1'b1 : tail_q;
        count_d   = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        rf_we_d   = wb_win || pop;
        rf_dest_d = wb_win ? wbDest : pop ? dest_q[head_q] : rf_dest_q;
        rf_val_d  = wb_win ? wbVal : pop ? val_q[head_q] : rf_val_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            rf_we_q   <= 1'b0;
            rf_dest_q <= '0;
            rf_val_q  <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            rf_we_q   <= rf_we_d;
            rf_dest_q <= rf_dest_d;
            rf_val_q  <= rf_val_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            dest_q[tail_q] <= luDest;
            val_q[tail_q]  <= luVal;
        end
    end

`ifdef SCOREBOARD_EN
    logic [31:0] busy_q, busy_d;

    // Clear on pop first, then set on issue, so a same-edge reissue keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        if (pop) busy_d[dest_q[head_q]] = 1'b0;
        if (issueEn) busy_d[issueDest] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    assign hazard = !rst && (busy_q[src1] || busy_q[src2]);
`else
    logic unused_ok;
    assign unused_ok = ^{issueEn, issueDest, src1, src2};
    assign hazard    = 1'b0;
`endif
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: randomized + directed scoreboard bench against a queue-based reference model
module tb_reg_write_arbiter;
    localparam int QD = 2;

    typedef struct {
        logic [4:0]  d;
        logic [31:0] v;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wbEn = 1'b0, luValid = 1'b0, issueEn = 1'b0;
    logic [4:0]  wbDest = '0, luDest = '0, issueDest = '0, src1 = '0, src2 = '0;
    logic [31:0] wbVal = '0, luVal = '0;
    logic        luReady, hazard, rfWriteEn;
    logic [4:0]  rfDest;
    logic [31:0] rfWriteVal;
    logic [$clog2(QD):0] qCount;

    reg_write_arbiter #(.QDEPTH(QD)) dut (
        .clk(clk), .rst(rst),
        .wbEn(wbEn), .wbDest(wbDest), .wbVal(wbVal),
        .luValid(luValid), .luDest(luDest), .luVal(luVal), .luReady(luReady),
        .issueEn(issueEn), .issueDest(issueDest),
        .src1(src1), .src2(src2), .hazard(hazard),
        .rfWriteEn(rfWriteEn), .rfDest(rfDest), .rfWriteVal(rfWriteVal),
        .qCount(qCount)
    );

    always #5 clk = ~clk;

    ent_t        mq[$];
    ent_t        exp_q[$];
    bit          busy[32];
    logic [4:0]  m_dest;
    logic [31:0] m_val;
    int          checks = 0, errors = 0;
    bit          started = 0;
    bit          lu_acc = 0;

    function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endfunction

    // Reference model: a FIFO of pending results, a busy set, and the arbitration rule.
    always @(posedge clk) begin : model
        bit   ready;
        ent_t e;
        if (rst) begin
            mq.delete();
            busy   = '{default: 1'b0};
            m_dest = '0;
            m_val  = '0;
        end else begin
            ready = mq.size() < QD;
            if (wbEn && wbDest != 0) begin
                m_dest = wbDest;
                m_val  = wbVal;
                exp_q.push_back('{d: wbDest, v: wbVal});
            end else if (mq.size() > 0) begin
                e      = mq.pop_front();
                m_dest = e.d;
                m_val  = e.v;
                busy[e.d] = 1'b0;
                exp_q.push_back(e);
            end
            if (luValid && ready && luDest != 0) mq.push_back('{d: luDest, v: luVal});
            if (issueEn && issueDest != 0) busy[issueDest] = 1'b1;
        end
    end

    // Monitor: compare at negedge, away from the active edge.
    always @(negedge clk) begin : monitor
        bit   exp_haz;
        ent_t e;
        if (started) begin
`ifdef SCOREBOARD_EN
            exp_haz = !rst && (busy[src1] || busy[src2]);
`else
            exp_haz = 1'b0;
`endif
            chk("rfWriteEn", rfWriteEn, exp_q.size() > 0);
            if (rfWriteEn || exp_q.size() > 0) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("write_dest", rfDest, e.d);
                    chk("write_val", rfWriteVal, e.v);
                end
            end
            chk("rfDest_hold", rfDest, m_dest);
            chk("rfWriteVal_hold", rfWriteVal, m_val);
            chk("qCount", qCount, mq.size());
            chk("luReady", luReady, !rst && mq.size() < QD);
            chk("hazard", hazard, exp_haz);
        end
    end

    task automatic step();
        lu_acc = luValid && luReady;
        @(posedge clk);
        #2;
    endtask

    task automatic push_lu(input logic [4:0] d, input logic [31:0] v, input bit drop_wb);
        bit ok;
        ok = 0;
        luValid = 1; luDest = d; luVal = v;
        for (int t = 0; t < 20 && !ok; t++) begin
            if (drop_wb && t == 4) wbEn = 0;
            step();
            ok = lu_acc;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL lu_accept_timeout: got 0 expected 1 for dest %0d", d);
        end
        luValid = 0;
    endtask

    initial begin
        // Reset with a producer already asserting luValid.
        luValid = 1; luDest = 5'd6; luVal = 32'h1234;
        @(posedge clk); #2;
        started = 1;
        step();
        rst = 0; luValid = 0;
        step();

        // WB priority over a queued result.
        luValid = 1; luDest = 5'd5; luVal = 32'hAAAA;
        step();
        luValid = 0;
        wbEn = 1; wbDest = 5'd3; wbVal = 32'h1111;
        repeat (3) step();
        wbEn = 0;
        repeat (3) step();

        // Full queue with continuous WB, then drain in FIFO order.
        wbEn = 1; wbDest = 5'd9; wbVal = 32'h9999;
        push_lu(5'd10, 32'hA0, 0);
        push_lu(5'd11, 32'hA1, 0);
        push_lu(5'd12, 32'hA2, 1);
        wbEn = 0;
        repeat (4) step();

        // Register 0 everywhere.
        wbEn = 1; wbDest = 0; wbVal = 32'hDEAD;
        luValid = 1; luDest = 0; luVal = 32'hBEEF;
        issueEn = 1; issueDest = 0; src1 = 0; src2 = 0;
        repeat (2) step();
        wbEn = 0; luValid = 0; issueEn = 0;
        step();

        // Scoreboard set / clear / same-edge reissue.
        issueEn = 1; issueDest = 5'd7; src1 = 5'd7;
        step();
        issueEn = 0;
        repeat (2) step();
        luValid = 1; luDest = 5'd7; luVal = 32'h77;
        step();
        luValid = 0;
        repeat (2) step();
        luValid = 1; luDest = 5'd7; luVal = 32'h78;
        step();
        luValid = 0; issueEn = 1; issueDest = 5'd7;
        step();
        issueEn = 0;
        repeat (2) step();

        // Reset while two entries are queued and r4 is busy.
        wbEn = 1; wbDest = 5'd2; wbVal = 32'h22;
        issueEn = 1; issueDest = 5'd4;
        step();
        issueEn = 0;
        push_lu(5'd4, 32'h44, 0);
        push_lu(5'd8, 32'h88, 0);
        rst = 1; wbEn = 0; src1 = 5'd4;
        step();
        rst = 0;
        repeat (3) step();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if (!luValid || lu_acc) begin
                luValid = ($urandom % 2) == 0;
                luDest  = 5'($urandom % 32);
                luVal   = $urandom;
            end
            wbEn      = ($urandom % ((i / 500) % 2 == 0 ? 4 : 2)) == 0;
            wbDest    = 5'($urandom % 32);
            wbVal     = $urandom;
            issueEn   = ($urandom % 3) == 0;
            issueDest = 5'($urandom % 8);
            src1      = 5'($urandom % 8);
            src2      = 5'($urandom % 8);
            rst       = ($urandom % 250) == 0;
            step();
        end
        rst = 0; wbEn = 0; luValid = 0; issueEn = 0;
        repeat (8) step();
        chk("drain_empty", qCount, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
